key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1000000, meaning the number of consecutive equal synchronized samples needed to accept a level change (20 ms at 50 MHz); legal range 2 or more.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50000000, meaning the number of cycles the debounced key stays pressed before the long-press pulse fires; legal range greater than STABLE_CYCLES.
REQ-003 Port sys_clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-004 Port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port key_i, input, 1 bit: raw, bouncing, asynchronous push-button input; active-low (0 = pressed).
REQ-006 Port key_o, output, 1 bit: debounced key level, active-low; it is the intended d_i of the downstream falling-edge detector.
REQ-007 Port press_o, output, 1 bit: one-cycle pulse on each accepted press.
REQ-008 Port release_o, output, 1 bit: one-cycle pulse on each accepted release.
REQ-009 Port long_o, output, 1 bit: one-cycle pulse when a press has been held for LONG_CYCLES.

Function
REQ-010 key_i SHALL pass through a two-flop synchronizer; its output is called s.
REQ-011 The FSM SHALL have exactly four states:
- IDLE: released and stable.
- PRESS_CHK: candidate press.
- HELD: pressed and stable.
- REL_CHK: candidate release.
REQ-012 From IDLE, s=0 SHALL move to PRESS_CHK with the stability counter at 1.
REQ-013 In PRESS_CHK:
- s=0 increments the counter.
- When the counter reaches STABLE_CYCLES, the FSM enters HELD, key_o goes to 0 and press_o is 1 for that single cycle.
- s=1 at any point returns the FSM to IDLE with the counter cleared and no pulse.
REQ-014 In HELD, s=1 SHALL move to REL_CHK with the stability counter at 1.
REQ-015 In REL_CHK:
- s=1 increments the counter.
- When the counter reaches STABLE_CYCLES, the FSM enters IDLE, key_o goes to 1 and release_o is 1 for that single cycle.
- s=0 returns the FSM to HELD with the counter cleared.
REQ-016 Latency: a clean key_i edge SHALL appear on key_o exactly 2+STABLE_CYCLES rising edges later.
REQ-017 Hold counter behaviour:
- It clears on entry to HELD.
- It increments every cycle in HELD and REL_CHK.
- long_o pulses once on the cycle the count reaches LONG_CYCLES, then the counter saturates.
- There SHALL be at most one long_o per press.
REQ-018 A bounce during REL_CHK (return to HELD) SHALL NOT clear the hold counter.
REQ-019 All outputs SHALL be registered.
REQ-020 press_o, release_o and long_o SHALL be mutually exclusive in any cycle.
REQ-021 Counter widths SHALL be clog2(STABLE_CYCLES+1) and clog2(LONG_CYCLES+1) bits; the counters SHALL never wrap.

Reset
REQ-022 While sys_rst=1, the block SHALL hold:
- FSM in IDLE;
- key_o=1;
- press_o=0, release_o=0, long_o=0;
- all counters and both synchronizer flops at their idle values (synchronizer flops at 1).
REQ-023 Reset asserted mid-operation (any state) SHALL force the REQ-022 values immediately, without waiting for a clock edge; no pulse SHALL be emitted as a result of the reset.
REQ-024 After deassertion, a key_i already held low SHALL be treated as a fresh press, producing press_o after 2+STABLE_CYCLES edges.

Structure
REQ-025 The FSM state encodings and the default STABLE_CYCLES and LONG_CYCLES values SHALL reside in the shared key_pkg include file.
REQ-026 The two-flop synchronizer SHALL be a separate sub-module named sync_2ff, which is reusable by other input blocks.

Verification (STABLE_CYCLES=4, LONG_CYCLES=10)
REQ-027 Reset: assert sys_rst with key_i=0 -> key_o=1 and all pulses 0 during reset; no press_o within the first 5 edges after release; press_o at edge 6.
REQ-028 Clean press: key_i 1->0 before edge 0 and held -> key_o=0 from edge 6; press_o=1 only in cycle 6.
REQ-029 Bounce: key_i low for 3 cycles, high for 1, then low -> no press_o during the bounce; key_o falls 6 edges after the final falling edge.
REQ-030 Long press: hold key_i low for 25 cycles after press_o -> exactly one long_o, 10 cycles after press_o; none afterwards.
REQ-031 Release: from HELD, key_i 0->1 with a 1-cycle glitch back to 0 -> release_o occurs once, 6 edges after the last rising edge; key_o=1 from then.
REQ-032 Mid-operation reset: assert sys_rst asynchronously (between clock edges) in HELD -> key_o=1 immediately, with no release_o.

Source files
------------

// File: rtl/key_pkg.sv
// key_pkg: constants shared by the key input blocks.
//   KEY_STABLE_CYCLES_DEF : default debounce window (20 ms at 50 MHz)
//   KEY_LONG_CYCLES_DEF   : default long-press threshold (1 s at 50 MHz)
//   ST_*                  : key_debounce FSM state encodings
package key_pkg;

  localparam int unsigned KEY_STABLE_CYCLES_DEF = 1000000;
  localparam int unsigned KEY_LONG_CYCLES_DEF   = 50000000;

  localparam logic [1:0] ST_IDLE      = 2'd0;  // released and stable
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;  // candidate press
  localparam logic [1:0] ST_HELD      = 2'd2;  // pressed and stable
  localparam logic [1:0] ST_REL_CHK   = 2'd3;  // candidate release

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
// Reusable by any input block; both flops reset to RST_VAL.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk_i edges of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button debouncer with press/release/long-press pulses.
//   sys_clk   : system clock, all state on rising edge
//   sys_rst   : asynchronous active-high reset
//   key_i     : raw active-low key (0 = pressed)
//   key_o     : debounced active-low key level
//   press_o   : one-cycle pulse per accepted press
//   release_o : one-cycle pulse per accepted release
//   long_o    : one-cycle pulse once a press has been held LONG_CYCLES
// A level change is accepted on the edge that sees the STABLE_CYCLES-th
// consecutive equal synchronized sample, so a clean key_i edge reaches
// key_o 2+STABLE_CYCLES edges later.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = KEY_STABLE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = KEY_LONG_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_i,
  output logic key_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST   = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX    = LW'(LONG_CYCLES);

  logic          s;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] stab_q,  stab_d;
  logic [LW-1:0] hold_q,  hold_d;
  logic          key_q,   key_d;
  logic          press_q, press_d;
  logic          rel_q,   rel_d;
  logic          long_q,  long_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_rst),
    .d_i   (key_i),
    .q_o   (s)
  );

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    key_d   = key_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;

    // Hold time keeps running through release candidates, so a release
    // bounce that falls back to HELD does not restart the long-press timer.
    if (state_q == ST_HELD || state_q == ST_REL_CHK) begin
      if (hold_q != LONG_MAX) begin
        hold_d = hold_q + LW'(1);
      end
      long_d = (hold_q == LONG_LAST);
    end

    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_PRESS_CHK;
          stab_d  = SW'(1);
        end
      end
      ST_PRESS_CHK: begin
        if (s) begin
          state_d = ST_IDLE;
          stab_d  = '0;
        end else if (stab_q == STABLE_LAST) begin
          state_d = ST_HELD;
          stab_d  = '0;
          hold_d  = '0;
          key_d   = 1'b0;
          press_d = 1'b1;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      ST_HELD: begin
        if (s) begin
          state_d = ST_REL_CHK;
          stab_d  = SW'(1);
        end
      end
      ST_REL_CHK: begin
        if (!s) begin
          state_d = ST_HELD;
          stab_d  = '0;
        end else if (stab_q == STABLE_LAST) begin
          state_d = ST_IDLE;
          stab_d  = '0;
          hold_d  = '0;
          key_d   = 1'b1;
          rel_d   = 1'b1;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        stab_d  = '0;
        hold_d  = '0;
        key_d   = 1'b1;
      end
    endcase

    // A release accepted on the same edge the threshold is hit ends the
    // press; the release pulse wins so pulses stay mutually exclusive.
    if (rel_d) begin
      long_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      stab_q  <= '0;
      hold_q  <= '0;
      key_q   <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      key_q   <= key_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule
